// File: rtl/adder_serial_multibyte.sv
// -----------------------------------------------------------------------------
// adder_full_8bit
//   8-bit ripple-carry adder used as the byte-wide datapath of the serial adder.
//   Ports:
//     add   in  8  addend byte
//     aug   in  8  augend byte
//     preC  in  1  carry into bit 0
//     sum   out 8  byte sum
//     proC  out 1  carry out of bit 7
// -----------------------------------------------------------------------------
module adder_full_8bit (
   input  logic [7:0] add,
   input  logic [7:0] aug,
   input  logic       preC,
   output logic [7:0] sum,
   output logic       proC
);

   logic carry_chain;

   always_comb begin
      sum         = '0;
      carry_chain = preC;
      for (int i = 0; i < 8; i++) begin
         sum[i]      = add[i] ^ aug[i] ^ carry_chain;
         carry_chain = (add[i] & aug[i]) | (carry_chain & (add[i] ^ aug[i]));
      end
      proC = carry_chain;
   end

endmodule

// -----------------------------------------------------------------------------
// adder_serial_multibyte
//   Wide adder that processes two NBYTES-byte operands one byte per clock,
//   least significant byte first, through a single adder_full_8bit. The byte
//   carry is held in carry_r between cycles. The result is offered to a
//   consumer through an out_valid/out_ready handshake.
//
//   Ports:
//     clk          in   1  rising-edge clock
//     rst_n        in   1  asynchronous active-low reset
//     start        in   1  operation request, taken only while start_ready=1
//     start_ready  out  1  high in IDLE
//     op_add       in   W  addend, captured on the accept edge
//     op_aug       in   W  augend, captured on the accept edge
//     cin          in   1  carry into byte 0, captured on the accept edge
//     out_valid    out  1  result/cout/ovf valid, held until consumed
//     out_ready    in   1  consumer takes the result on out_valid & out_ready
//     result       out  W  sum modulo 2^W
//     cout         out  1  carry out of the top byte
//     ovf          out  1  two's complement signed overflow
//     busy         out  1  high in RUN
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; outputs keep the last result
//   RUN   | one byte added per edge, sum shifted into result from MSB
//   DONE  | out_valid high, result held until out_ready
// -----------------------------------------------------------------------------
module adder_serial_multibyte #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                start_ready,
   input  logic [8*NBYTES-1:0] op_add,
   input  logic [8*NBYTES-1:0] op_aug,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] result,
   output logic                cout,
   output logic                ovf,
   output logic                busy
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic          carry_r;
   logic [IW-1:0] idx;

   logic [7:0]    byte_sum;
   logic          byte_carry;

   adder_full_8bit u_byte_adder (
      .add  (a_sh[7:0]),
      .aug  (b_sh[7:0]),
      .preC (carry_r),
      .sum  (byte_sum),
      .proC (byte_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         a_sh        <= '0;
         b_sh        <= '0;
         carry_r     <= 1'b0;
         idx         <= '0;
         result      <= '0;
         cout        <= 1'b0;
         ovf         <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         start_ready <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh        <= op_add;
                  b_sh        <= op_aug;
                  carry_r     <= cin;
                  idx         <= '0;
                  state       <= S_RUN;
                  busy        <= 1'b1;
                  start_ready <= 1'b0;
               end
            end

            S_RUN: begin
               // After NBYTES shifts the first byte computed sits at the LSB.
               result  <= {byte_sum, result[W-1:8]};
               a_sh    <= {8'h00, a_sh[W-1:8]};
               b_sh    <= {8'h00, b_sh[W-1:8]};
               carry_r <= byte_carry;
               idx     <= idx + IDX_ONE;
               if (idx == LAST_IDX) begin
                  // a_sh/b_sh hold the top operand bytes here, so bit 7 is the sign.
                  cout      <= byte_carry;
                  ovf       <= (a_sh[7] == b_sh[7]) && (byte_sum[7] != a_sh[7]);
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  state       <= S_IDLE;
                  out_valid   <= 1'b0;
                  start_ready <= 1'b1;
               end
            end

            default: begin
               state       <= S_IDLE;
               out_valid   <= 1'b0;
               busy        <= 1'b0;
               start_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_serial_multibyte.sv
module tb_adder_serial_multibyte;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         start_ready;
   logic [W-1:0] op_add;
   logic [W-1:0] op_aug;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         busy;

   adder_serial_multibyte #(.NBYTES(NB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_ready (start_ready),
      .op_add      (op_add),
      .op_aug      (op_aug),
      .cin         (cin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .cout        (cout),
      .ovf         (ovf),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         v;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_popped = 0;

   // Reference: plain W-bit arithmetic with sign rules on the full words.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      exp_t         e;
      logic [W:0]   s;
      s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.r = s[W-1:0];
      e.c = s[W];
      e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (timeout) at cycle %0d", name, cyc);
   endtask

   // Monitor: pops one expectation per completed handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_popped++;
            check("result", result, e.r);
            check("cout", W'(cout), W'(e.c));
            check("ovf", W'(ovf), W'(e.v));
         end
      end
   end

   // Waits for start_ready, presents the operands, and returns just after the accept edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int budget;
      budget = 0;
      while (start_ready !== 1'b1 && budget < 50) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (start_ready !== 1'b1) fail_now("wait_start_ready");
      start  = 1'b1;
      op_add = a;
      op_aug = b;
      cin    = c;
      @(posedge clk);
      exp_q.push_back(model(a, b, c));
      #1;
      start  = 1'b0;
      // Operands changing after acceptance must not matter.
      op_add = W'($urandom);
      op_aug = W'($urandom);
      cin    = 1'($urandom);
      check("busy_in_run", W'(busy), W'(1));
      check("start_ready_in_run", W'(start_ready), W'(0));
   endtask

   // Counts edges from the accept edge until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1) lat++;
      end
      if (out_valid !== 1'b1) fail_now("wait_out_valid");
   endtask

   initial begin
      int   lat;
      int   prev_acc;
      exp_t e;
      logic [W-1:0] ra, rb;

      rst_n     = 1'b0;
      start     = 1'b0;
      op_add    = '0;
      op_aug    = '0;
      cin       = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_result", result, '0);
      check("rst_cout", W'(cout), W'(0));
      check("rst_ovf", W'(ovf), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_start_ready", W'(start_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors with latency and return-to-idle checks.
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
      wait_valid(lat);
      check("latency_1", W'(lat), W'(NB));
      @(posedge clk);
      #1;
      check("idle_after_handshake", W'(start_ready), W'(1));
      check("out_valid_low_idle", W'(out_valid), W'(0));

      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_valid(lat);
      check("latency_2", W'(lat), W'(NB));
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_valid(lat);
      issue(32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
      wait_valid(lat);
      @(posedge clk);
      #1;

      // Hold with out_ready low; start pulses during RUN and DONE must be ignored.
      out_ready = 1'b0;
      issue(32'h89AB_CDEF, 32'h7654_3210, 1'b1);
      e = model(32'h89AB_CDEF, 32'h7654_3210, 1'b1);
      start = 1'b1;
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         start  = ~start;
         op_add = W'($urandom);
         check("hold_out_valid", W'(out_valid), W'(1));
         check("hold_result", result, e.r);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_start_ready", W'(start_ready), W'(1));
      check("release_out_valid", W'(out_valid), W'(0));
      check("release_result_kept", result, e.r);
      repeat (3) @(posedge clk);
      #1;
      check("no_queued_start", W'(busy), W'(0));

      // Reset mid-RUN after two bytes.
      issue(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      check("abort_result", result, '0);
      check("abort_out_valid", W'(out_valid), W'(0));
      check("abort_busy", W'(busy), W'(0));
      check("abort_start_ready", W'(start_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_valid(lat);
      check("post_reset_result", result, 32'h2345_6789);
      @(posedge clk);
      #1;

      // Back-to-back: start held high, 200 random operand pairs.
      prev_acc = -1;
      start    = 1'b1;
      for (int k = 0; k < 200; k++) begin
         int budget;
         case ($urandom_range(0, 7))
            0:       ra = '1;
            1:       ra = 32'h8000_0000;
            default: ra = W'($urandom);
         endcase
         rb     = ($urandom_range(0, 7) == 0) ? ~ra : W'($urandom);
         op_add = ra;
         op_aug = rb;
         cin    = 1'($urandom);
         budget = 0;
         while (start_ready !== 1'b1 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
         end
         if (start_ready !== 1'b1) begin
            fail_now("b2b_wait_ready");
            break;
         end
         @(posedge clk);
         exp_q.push_back(model(ra, rb, cin));
         #1;
         if (prev_acc >= 0) check("b2b_spacing", W'(cyc - prev_acc), W'(NB + 2));
         prev_acc = cyc;
         op_add   = W'($urandom);
         op_aug   = W'($urandom);
      end
      start = 1'b0;

      for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      check("queue_drained", W'(exp_q.size()), W'(0));
      check("outputs_seen", W'(n_popped), W'(206));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
